// File: rtl/uart_tx_feeder.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_feeder
// Brief   : Circular byte FIFO draining CPU writes into a UART transmitter.
//           Optional low-water irq enabled by macro UART_TX_FEEDER_IRQ_EN.
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_feeder #(
  parameter int DEPTH_LOG2 = 4,
  parameter int IRQ_LEVEL  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_reg_dat_we,
  input  logic [31:0] i_reg_dat_di,
  output logic        o_reg_dat_wait,
  output logic [31:0] o_reg_sts_do,
  input  logic        i_reg_sts_clr,
  output logic        o_uart_dat_we,
  output logic [31:0] o_uart_dat_di,
  input  logic        i_uart_dat_wait,
  output logic        o_irq
);

  localparam int                  DEPTH       = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_FULL_LVL  = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] c_LVL_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t                r_state;
  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  r_overflow;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic [DEPTH_LOG2:0]   w_level_next;
  logic                  w_unused_di;

  assign w_unused_di = ^i_reg_dat_di[31:8];

  always_comb begin
    w_full  = (r_level == c_FULL_LVL);
    w_empty = (r_level == '0);
    w_push  = i_reg_dat_we && !w_full;
    w_pop   = (r_state == S_SEND) && !i_uart_dat_wait;
    case ({w_push, w_pop})
      2'b10:   w_level_next = r_level + c_LVL_ONE;
      2'b01:   w_level_next = r_level - c_LVL_ONE;
      default: w_level_next = r_level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_reg_dat_di[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_level <= w_level_next;
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      // A write against a full FIFO is lost even if a pop frees a slot this cycle
      if (i_reg_dat_we && w_full) r_overflow <= 1'b1;
      else if (i_reg_sts_clr)     r_overflow <= 1'b0;
      case (r_state)
        S_IDLE:  if (!w_empty && !i_uart_dat_wait) r_state <= S_SEND;
        S_SEND:  if (!i_uart_dat_wait) r_state <= S_GAP;
        S_GAP:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_reg_sts_do      = '0;
    o_reg_sts_do[8:0] = 9'(r_level);
    o_reg_sts_do[16]  = w_empty;
    o_reg_sts_do[17]  = w_full;
    o_reg_sts_do[24]  = r_overflow;
  end

  assign o_reg_dat_wait = w_full;
  assign o_uart_dat_we  = (r_state == S_SEND);
  assign o_uart_dat_di  = {24'b0, r_mem[r_rd_ptr]};

`ifdef UART_TX_FEEDER_IRQ_EN
  localparam logic [DEPTH_LOG2:0] c_IRQ_LVL = (DEPTH_LOG2 + 1)'(IRQ_LEVEL);
  logic r_irq;
  logic r_armed;

  // Held low after reset until the first byte arrives, then tracks the low-water mark
  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq   <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      if (w_push) r_armed <= 1'b1;
      r_irq <= (r_armed || w_push) && (w_level_next <= c_IRQ_LVL);
    end
  end

  assign o_irq = r_irq;
`else
  assign o_irq = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_feeder.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx_feeder
// Brief   : Self-checking bench for uart_tx_feeder against a queue-based model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_tx_feeder;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_reg_dat_we = 1'b0;
  logic [31:0] i_reg_dat_di = '0;
  logic        o_reg_dat_wait;
  logic [31:0] o_reg_sts_do;
  logic        i_reg_sts_clr = 1'b0;
  logic        o_uart_dat_we;
  logic [31:0] o_uart_dat_di;
  logic        i_uart_dat_wait = 1'b0;
  logic        o_irq;

  int vectors = 0;
  int miscompares = 0;

  uart_tx_feeder #(.DEPTH_LOG2(4), .IRQ_LEVEL(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_reg_dat_we   (i_reg_dat_we),
    .i_reg_dat_di   (i_reg_dat_di),
    .o_reg_dat_wait (o_reg_dat_wait),
    .o_reg_sts_do   (o_reg_sts_do),
    .i_reg_sts_clr  (i_reg_sts_clr),
    .o_uart_dat_we  (o_uart_dat_we),
    .o_uart_dat_di  (o_uart_dat_di),
    .i_uart_dat_wait(i_uart_dat_wait),
    .o_irq          (o_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] exp_sts(input int lvl, input bit ovf);
    return {7'b0, ovf, 6'b0, lvl == DEPTH, lvl == 0, 7'b0, 9'(lvl)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; i_reg_dat_we = 1'b0; i_reg_sts_clr = 1'b0; i_uart_dat_wait = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic push_n(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      i_reg_dat_we = 1'b1;
      i_reg_dat_di = {24'($urandom), 8'(base + i)};
      step();
    end
    i_reg_dat_we = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (o_reg_sts_do !== exp_sts(0, 0)) begin
      miscompares++; $display("FAIL reset_sts: got %h want %h", o_reg_sts_do, exp_sts(0, 0));
    end
    vectors++;
    if (o_uart_dat_we !== 1'b0 || o_reg_dat_wait !== 1'b0 || o_irq !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outs: got we=%b wait=%b irq=%b want 0 0 0", o_uart_dat_we, o_reg_dat_wait, o_irq);
    end
  endtask

  task automatic test_single();
    do_reset();
    i_reg_dat_we = 1'b1;
    i_reg_dat_di = {24'($urandom), 8'h55};
    step();
    i_reg_dat_we = 1'b0;
    vectors++;
    if (o_uart_dat_we !== 1'b0 || o_reg_sts_do !== exp_sts(1, 0)) begin
      miscompares++; $display("FAIL single_c1: got we=%b sts=%h want we=0 sts=%h", o_uart_dat_we, o_reg_sts_do, exp_sts(1, 0));
    end
    step();
    vectors++;
    if (o_uart_dat_we !== 1'b1 || o_uart_dat_di !== 32'h0000_0055) begin
      miscompares++; $display("FAIL single_c2: got we=%b di=%h want we=1 di=00000055", o_uart_dat_we, o_uart_dat_di);
    end
    step();
    vectors++;
    if (o_uart_dat_we !== 1'b0 || o_reg_sts_do !== exp_sts(0, 0)) begin
      miscompares++; $display("FAIL single_c3: got we=%b sts=%h want we=0 sts=%h", o_uart_dat_we, o_reg_sts_do, exp_sts(0, 0));
    end
    step();
    vectors++;
    if (o_uart_dat_we !== 1'b0) begin
      miscompares++; $display("FAIL single_c4: got we=%b want 0", o_uart_dat_we);
    end
  endtask

  task automatic test_fill();
    do_reset();
    i_uart_dat_wait = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      i_reg_dat_we = 1'b1;
      i_reg_dat_di = {24'($urandom), 8'(i)};
      step();
      vectors++;
      if (o_reg_dat_wait !== (i >= DEPTH - 1)) begin
        miscompares++; $display("FAIL fill_wait_%0d: got %b want %b", i, o_reg_dat_wait, i >= DEPTH - 1);
      end
    end
    i_reg_dat_we = 1'b0;
    vectors++;
    if (o_reg_sts_do !== exp_sts(DEPTH, 1)) begin
      miscompares++; $display("FAIL fill_ovf: got %h want %h", o_reg_sts_do, exp_sts(DEPTH, 1));
    end
    i_reg_sts_clr = 1'b1;
    step();
    i_reg_sts_clr = 1'b0;
    vectors++;
    if (o_reg_sts_do !== exp_sts(DEPTH, 0)) begin
      miscompares++; $display("FAIL fill_clr: got %h want %h", o_reg_sts_do, exp_sts(DEPTH, 0));
    end
  endtask

  task automatic test_busy_collision();
    logic [7:0] bx, by;
    bx = 8'($urandom); by = 8'($urandom);
    do_reset();
    i_reg_dat_we = 1'b1; i_reg_dat_di = {24'($urandom), bx};
    step();
    i_reg_dat_di = {24'($urandom), by};
    step();
    i_reg_dat_we = 1'b0;
    vectors++;
    if (o_uart_dat_we !== 1'b1 || o_uart_dat_di !== {24'b0, bx} || o_reg_sts_do !== exp_sts(2, 0)) begin
      miscompares++; $display("FAIL coll_send: got we=%b di=%h sts=%h want we=1 di=%h sts=%h",
                              o_uart_dat_we, o_uart_dat_di, o_reg_sts_do, {24'b0, bx}, exp_sts(2, 0));
    end
    i_uart_dat_wait = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (o_uart_dat_we !== 1'b1 || o_uart_dat_di !== {24'b0, bx} || o_reg_sts_do !== exp_sts(2, 0)) begin
        miscompares++; $display("FAIL coll_hold_%0d: got we=%b di=%h sts=%h want we=1 di=%h sts=%h",
                                i, o_uart_dat_we, o_uart_dat_di, o_reg_sts_do, {24'b0, bx}, exp_sts(2, 0));
      end
    end
    i_uart_dat_wait = 1'b0;
    step();
    i_uart_dat_wait = 1'b1;
    vectors++;
    if (o_uart_dat_we !== 1'b0 || o_reg_sts_do !== exp_sts(1, 0)) begin
      miscompares++; $display("FAIL coll_pop: got we=%b sts=%h want we=0 sts=%h", o_uart_dat_we, o_reg_sts_do, exp_sts(1, 0));
    end
    step(); step();
    vectors++;
    if (o_uart_dat_we !== 1'b0 || o_reg_sts_do !== exp_sts(1, 0)) begin
      miscompares++; $display("FAIL coll_onepop: got we=%b sts=%h want we=0 sts=%h", o_uart_dat_we, o_reg_sts_do, exp_sts(1, 0));
    end
    i_uart_dat_wait = 1'b0;
    step();
    vectors++;
    if (o_uart_dat_we !== 1'b1 || o_uart_dat_di !== {24'b0, by}) begin
      miscompares++; $display("FAIL coll_next: got we=%b di=%h want we=1 di=%h", o_uart_dat_we, o_uart_dat_di, {24'b0, by});
    end
    step();
  endtask

  task automatic test_simultaneous();
    do_reset();
    i_uart_dat_wait = 1'b1;
    push_n(DEPTH, 0);
    i_uart_dat_wait = 1'b0;
    step();
    vectors++;
    if (o_uart_dat_we !== 1'b1 || o_uart_dat_di !== 32'h0) begin
      miscompares++; $display("FAIL simul_send: got we=%b di=%h want we=1 di=00000000", o_uart_dat_we, o_uart_dat_di);
    end
    i_reg_dat_we = 1'b1; i_reg_dat_di = {24'($urandom), 8'hAA};
    step();
    i_reg_dat_we = 1'b0; i_uart_dat_wait = 1'b1;
    vectors++;
    if (o_reg_sts_do !== exp_sts(DEPTH - 1, 1)) begin
      miscompares++; $display("FAIL simul_full: got %h want %h", o_reg_sts_do, exp_sts(DEPTH - 1, 1));
    end
    do_reset();
    i_uart_dat_wait = 1'b1;
    push_n(5, 8'h10);
    i_uart_dat_wait = 1'b0;
    step();
    i_reg_dat_we = 1'b1; i_reg_dat_di = {24'($urandom), 8'h77};
    step();
    i_reg_dat_we = 1'b0; i_uart_dat_wait = 1'b1;
    vectors++;
    if (o_reg_sts_do !== exp_sts(5, 0)) begin
      miscompares++; $display("FAIL simul_lvl5: got %h want %h", o_reg_sts_do, exp_sts(5, 0));
    end
  endtask

  task automatic test_order_wrap();
    byte unsigned data[40];
    byte unsigned q[$];
    int sent, recv, busy, cyc;
    bit acc, pushing;
    sent = 0; recv = 0; busy = 0; cyc = 0;
    for (int i = 0; i < 40; i++) data[i] = 8'($urandom);
    do_reset();
    while (recv < 40 && cyc < 3000) begin
      i_uart_dat_wait = (busy > 0);
      vectors++;
      if (o_reg_dat_wait !== (q.size() == DEPTH) || o_reg_sts_do[8:0] !== 9'(q.size())) begin
        miscompares++; $display("FAIL order_lvl_c%0d: got wait=%b lvl=%0d want wait=%b lvl=%0d",
                                cyc, o_reg_dat_wait, o_reg_sts_do[8:0], q.size() == DEPTH, q.size());
      end
      pushing = (sent < 40) && !o_reg_dat_wait && ($urandom_range(0, 3) != 0);
      i_reg_dat_we = pushing;
      if (pushing) i_reg_dat_di = {24'($urandom), data[sent]};
      acc = o_uart_dat_we && !i_uart_dat_wait;
      if (acc) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++; $display("FAIL order_spurious_c%0d: got send of %h want no send", cyc, o_uart_dat_di);
        end else begin
          if (o_uart_dat_di !== {24'b0, q[0]}) begin
            miscompares++; $display("FAIL order_byte_%0d: got %h want %h", recv, o_uart_dat_di, {24'b0, q[0]});
          end
          void'(q.pop_front());
        end
        recv++;
      end
      if (pushing) begin
        q.push_back(data[sent]);
        sent++;
      end
      step();
      cyc++;
      if (acc) busy = 10;
      else if (busy > 0) busy--;
`ifndef UART_TX_FEEDER_IRQ_EN
      vectors++;
      if (o_irq !== 1'b0) begin
        miscompares++; $display("FAIL order_irq_c%0d: got %b want 0", cyc, o_irq);
      end
`endif
    end
    i_reg_dat_we = 1'b0;
    vectors++;
    if (recv != 40 || sent != 40) begin
      miscompares++; $display("FAIL order_timeout: got recv=%0d sent=%0d want 40 40", recv, sent);
    end
    step(); step();
    vectors++;
    if (o_reg_sts_do !== exp_sts(0, 0)) begin
      miscompares++; $display("FAIL order_empty: got %h want %h", o_reg_sts_do, exp_sts(0, 0));
    end
  endtask

  task automatic test_midop_reset();
    do_reset();
    i_uart_dat_wait = 1'b1;
    push_n(7, $urandom_range(0, 200));
    i_uart_dat_wait = 1'b0;
    step();
    vectors++;
    if (o_uart_dat_we !== 1'b1 || o_reg_sts_do !== exp_sts(7, 0)) begin
      miscompares++; $display("FAIL midrst_pre: got we=%b sts=%h want we=1 sts=%h", o_uart_dat_we, o_reg_sts_do, exp_sts(7, 0));
    end
    rst = 1'b1;
    step();
    vectors++;
    if (o_uart_dat_we !== 1'b0 || o_reg_sts_do !== exp_sts(0, 0) || o_irq !== 1'b0) begin
      miscompares++; $display("FAIL midrst_post: got we=%b sts=%h irq=%b want we=0 sts=%h irq=0",
                              o_uart_dat_we, o_reg_sts_do, o_irq, exp_sts(0, 0));
    end
    rst = 1'b0;
    step();
    vectors++;
    if (o_uart_dat_we !== 1'b0) begin
      miscompares++; $display("FAIL midrst_idle: got we=%b want 0", o_uart_dat_we);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_busy_collision();
    test_simultaneous();
    test_order_wrap();
    test_midop_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
